// File: rtl/mioc_flop_pkg.sv
// -----------------------------------------------------------------------------
// mioc_flop_pkg
//
// Shared constants and the next-state helper for the MIOC set/reset flop bank.
//
// Contents:
//   MIOC_FLOP_MAX_CHANNELS : upper bound on the CHANNELS parameter
//   MIOC_FLOP_CNT_W        : width of the per-input stability counter used
//                            when MIOC_FLOP_FILTER_EN is defined
//   MIOC_PRI_CLR / _SET    : SET_DOMINANT encodings (clear wins / set wins)
//   MIOC_IDX_*             : bit positions of the conditioned set, clear and
//                            falling-edge-clear inputs in a channel's 3-bit bus
//   mioc_flop_next()       : priority-resolved next state of one flop
// -----------------------------------------------------------------------------
package mioc_flop_pkg;

  localparam int MIOC_FLOP_MAX_CHANNELS = 32;
  localparam int MIOC_FLOP_CNT_W        = 4;

  localparam int MIOC_PRI_CLR = 0;
  localparam int MIOC_PRI_SET = 1;

  localparam int MIOC_IDX_SET  = 0;
  localparam int MIOC_IDX_CLR  = 1;
  localparam int MIOC_IDX_FALL = 2;

  // Resolve one flop's next state. 'clr' is the union of the level clear and
  // the one-cycle falling-edge clear. When neither request is active the
  // current state is held.
  function automatic logic mioc_flop_next(
    input logic q,
    input logic s,
    input logic clr,
    input logic set_wins
  );
    logic nxt;
    nxt = q;
    if (set_wins) begin
      if (s)        nxt = 1'b1;
      else if (clr) nxt = 1'b0;
    end else begin
      if (clr)      nxt = 1'b0;
      else if (s)   nxt = 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mioc_flop_chan.sv
// -----------------------------------------------------------------------------
// mioc_flop_chan
//
// One channel of the MIOC set/reset flop bank. It takes three asynchronous
// control strobes and does the following:
//   - synchronises each strobe,
//   - optionally filters each one for stability,
//   - detects the falling edge of the edge-clear input,
//   - resolves set/clear priority into the state flop,
//   - produces a one-cycle change strobe.
//
// Optional feature: define MIOC_FLOP_FILTER_EN to insert a FILTER_CYCLES
// stability filter after each synchroniser. When the macro is undefined the
// conditioned value is the synchronised value and no counters exist.
//
// Parameters:
//   SYNC_STAGES   : synchroniser depth per input (>= 2)
//   SET_DOMINANT  : MIOC_PRI_CLR (clear wins) or MIOC_PRI_SET (set wins)
//   FILTER_CYCLES : stability count, 1..15 (filter builds only)
//
// Ports:
//   clk        in  : block clock
//   rst_n      in  : asynchronous active-low reset
//   set_i      in  : level set, asynchronous
//   clr_i      in  : level clear, asynchronous
//   clr_fall_i in  : clear on falling edge, asynchronous
//   q          out : flop state
//   qbar       out : ~q
//   chg        out : high for one cycle when q changed on the previous clock
// -----------------------------------------------------------------------------
module mioc_flop_chan
  import mioc_flop_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SET_DOMINANT  = MIOC_PRI_CLR,
  parameter int FILTER_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_i,
  input  logic clr_i,
  input  logic clr_fall_i,
  output logic q,
  output logic qbar,
  output logic chg
);

  localparam logic SET_WINS = (SET_DOMINANT == MIOC_PRI_SET);

  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_bad_filter_cycles
    $error("mioc_flop_chan: FILTER_CYCLES must be in 1..15");
  end

  logic [SYNC_STAGES-1:0] set_sync;
  logic [SYNC_STAGES-1:0] clr_sync;
  logic [SYNC_STAGES-1:0] fall_sync;
  logic [2:0]             raw;
  logic [2:0]             cond;
  logic                   f_prev;
  logic                   fe;
  logic                   q_nxt;
  logic                   q_d;

  // ---- stage: synchronisers (bit 0 is the metastable capture flop) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_sync  <= '0;
      clr_sync  <= '0;
      fall_sync <= '0;
    end else begin
      set_sync  <= {set_sync[SYNC_STAGES-2:0],  set_i};
      clr_sync  <= {clr_sync[SYNC_STAGES-2:0],  clr_i};
      fall_sync <= {fall_sync[SYNC_STAGES-2:0], clr_fall_i};
    end
  end

  always_comb begin
    raw                = '0;
    raw[MIOC_IDX_SET]  = set_sync[SYNC_STAGES-1];
    raw[MIOC_IDX_CLR]  = clr_sync[SYNC_STAGES-1];
    raw[MIOC_IDX_FALL] = fall_sync[SYNC_STAGES-1];
  end

`ifdef MIOC_FLOP_FILTER_EN
  // ---- stage: stability filter ----
  // A counter advances on each cycle when the synchronised value differs
  // from the filtered value. The filtered value flips on the
  // FILTER_CYCLES-th consecutive differing cycle. Any agreeing cycle
  // discards the partial count.
  localparam logic [MIOC_FLOP_CNT_W-1:0] FC_LAST =
    MIOC_FLOP_CNT_W'(FILTER_CYCLES - 1);

  logic [2:0]                      filt;
  logic [2:0][MIOC_FLOP_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= '0;
      cnt  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (raw[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == FC_LAST) begin
          filt[i] <= raw[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign cond = filt;
`else
  assign cond = raw;
`endif

  // f_prev resets to 0. An edge-clear input that is high across reset
  // release therefore rises 0->1 here, which is not a falling edge.
  assign fe    = f_prev & ~cond[MIOC_IDX_FALL];
  assign q_nxt = mioc_flop_next(q, cond[MIOC_IDX_SET],
                                cond[MIOC_IDX_CLR] | fe, SET_WINS);

  // ---- stage: edge history, state flop, change strobe ----
  // chg compares q with q_d, its copy from one clock earlier. The strobe
  // therefore appears one clock after q moves and lasts one cycle per
  // change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_prev <= 1'b0;
      q      <= 1'b0;
      q_d    <= 1'b0;
      chg    <= 1'b0;
    end else begin
      f_prev <= cond[MIOC_IDX_FALL];
      q      <= q_nxt;
      q_d    <= q;
      chg    <= q ^ q_d;
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/mioc_flop_bank.sv
// -----------------------------------------------------------------------------
// mioc_flop_bank
//
// Bank of CHANNELS independent clocked set/reset flops. This is the
// synchronous successor to the open-drain MIOC set/reset flop. Each channel
// has the following inputs:
//   - a level set,
//   - a level clear,
//   - a falling-edge clear.
// Every input is synchronised to clk. Channels do not interact.
//
// Optional feature: MIOC_FLOP_FILTER_EN adds a per-input stability filter
// (see mioc_flop_chan).
//
// Parameters:
//   CHANNELS      : number of channels, 1..32
//   SYNC_STAGES   : synchroniser depth per input, >= 2
//   SET_DOMINANT  : 0 = clear wins on conflict, 1 = set wins
//   FILTER_CYCLES : filter stability count, 1..15 (filter builds only)
//
// Ports:
//   clk        in  [1]        : block clock
//   rst_n      in  [1]        : asynchronous active-low reset
//   set_i      in  [CHANNELS] : level set, asynchronous
//   clr_i      in  [CHANNELS] : level clear, asynchronous
//   clr_fall_i in  [CHANNELS] : falling-edge clear, asynchronous
//   q          out [CHANNELS] : flop state
//   qbar       out [CHANNELS] : ~q
//   chg        out [CHANNELS] : one-cycle change strobe per channel
// -----------------------------------------------------------------------------
module mioc_flop_bank
  import mioc_flop_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int SET_DOMINANT  = 0,
  parameter int FILTER_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] set_i,
  input  logic [CHANNELS-1:0] clr_i,
  input  logic [CHANNELS-1:0] clr_fall_i,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] qbar,
  output logic [CHANNELS-1:0] chg
);

  if (CHANNELS < 1 || CHANNELS > MIOC_FLOP_MAX_CHANNELS) begin : g_bad_channels
    $error("mioc_flop_bank: CHANNELS must be in 1..32");
  end

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("mioc_flop_bank: SYNC_STAGES must be at least 2");
  end

  if (SET_DOMINANT != MIOC_PRI_CLR && SET_DOMINANT != MIOC_PRI_SET) begin : g_bad_set_dominant
    $error("mioc_flop_bank: SET_DOMINANT must be 0 or 1");
  end

  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_bad_filter_cycles
    $error("mioc_flop_bank: FILTER_CYCLES must be in 1..15");
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
    mioc_flop_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .SET_DOMINANT (SET_DOMINANT),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_i     (set_i[n]),
      .clr_i     (clr_i[n]),
      .clr_fall_i(clr_fall_i[n]),
      .q         (q[n]),
      .qbar      (qbar[n]),
      .chg       (chg[n])
    );
  end

endmodule

// File: tb/tb_mioc_flop_bank.sv
module tb_mioc_flop_bank;

  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int FC   = 3;
`ifdef MIOC_FLOP_FILTER_EN
  localparam int PW  = FC;
  localparam int LAT = SYNC + FC + 1;
`else
  localparam int PW  = 1;
  localparam int LAT = SYNC + 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] set_i = '0;
  logic [CH-1:0] clr_i = '0;
  logic [CH-1:0] clr_fall_i = '1;
  logic [CH-1:0] q0, qb0, chg0;
  logic [CH-1:0] q1, qb1, chg1;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mioc_flop_bank #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .SET_DOMINANT(0), .FILTER_CYCLES(FC)
  ) u_dut_clr (
    .clk(clk), .rst_n(rst_n), .set_i(set_i), .clr_i(clr_i),
    .clr_fall_i(clr_fall_i), .q(q0), .qbar(qb0), .chg(chg0)
  );

  mioc_flop_bank #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .SET_DOMINANT(1), .FILTER_CYCLES(FC)
  ) u_dut_set (
    .clk(clk), .rst_n(rst_n), .set_i(set_i), .clr_i(clr_i),
    .clr_fall_i(clr_fall_i), .q(q1), .qbar(qb1), .chg(chg1)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; set_i = '0; clr_i = '0; clr_fall_i = '1;
    tick(3);
    total++; if (q0 !== 4'b0000) $display("FAIL reset_q0: got %b want 0000", q0); else passed++;
    total++; if (qb0 !== 4'b1111) $display("FAIL reset_qbar0: got %b want 1111", qb0); else passed++;
    total++; if (chg0 !== 4'b0000) $display("FAIL reset_chg0: got %b want 0000", chg0); else passed++;
    total++; if ({q1, qb1, chg1} !== 12'h0F0) $display("FAIL reset_dut1: got %h want 0f0", {q1, qb1, chg1}); else passed++;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      total++;
      if ({q0, qb0, chg0, q1, qb1, chg1} !== 24'h0F00F0)
        $display("FAIL release_idle[%0d]: got %h want 0f00f0", i, {q0, qb0, chg0, q1, qb1, chg1});
      else passed++;
    end
  endtask

  task automatic test_set_pulse();
    set_i[0] = 1'b1;
    tick(PW);
    set_i[0] = 1'b0;
    tick(LAT - PW - 1);
    total++; if (q0 !== 4'b0000) $display("FAIL set_early: got %b want 0000", q0); else passed++;
    tick(1);
    total++; if (q0 !== 4'b0001) $display("FAIL set_q0: got %b want 0001", q0); else passed++;
    total++; if (q1 !== 4'b0001) $display("FAIL set_q1: got %b want 0001", q1); else passed++;
    total++; if (chg0 !== 4'b0000) $display("FAIL set_chg_early: got %b want 0000", chg0); else passed++;
    tick(1);
    total++; if (chg0 !== 4'b0001) $display("FAIL set_chg_pulse: got %b want 0001", chg0); else passed++;
    total++; if (qb0 !== 4'b1110) $display("FAIL set_qbar: got %b want 1110", qb0); else passed++;
    tick(1);
    total++; if (chg0 !== 4'b0000) $display("FAIL set_chg_end: got %b want 0000", chg0); else passed++;
  endtask

  task automatic test_fall_clear();
    set_i[1] = 1'b1;
    tick(PW);
    set_i[1] = 1'b0;
    tick(LAT + 2);
    total++; if (q0 !== 4'b0011) $display("FAIL fall_preset: got %b want 0011", q0); else passed++;
    clr_fall_i[1] = 1'b0;
    tick(LAT - 1);
    total++; if (q0 !== 4'b0011) $display("FAIL fall_early: got %b want 0011", q0); else passed++;
    tick(1);
    total++; if (q0 !== 4'b0001) $display("FAIL fall_clear_q0: got %b want 0001", q0); else passed++;
    total++; if (q1 !== 4'b0001) $display("FAIL fall_clear_q1: got %b want 0001", q1); else passed++;
    tick(LAT + 3);
    set_i[1] = 1'b1;
    tick(PW);
    set_i[1] = 1'b0;
    tick(LAT - PW);
    total++; if (q0 !== 4'b0011) $display("FAIL fall_reset_after_low: got %b want 0011", q0); else passed++;
    tick(3);
    total++; if (q0 !== 4'b0011) $display("FAIL fall_held_low_hold: got %b want 0011", q0); else passed++;
  endtask

  task automatic test_priority();
    set_i[3] = 1'b1;
    tick(PW);
    set_i[3] = 1'b0;
    tick(LAT + 2);
    total++; if (q0 !== 4'b1011) $display("FAIL pri_preset: got %b want 1011", q0); else passed++;
    set_i[3] = 1'b1; clr_i[3] = 1'b1;
    tick(LAT);
    for (int i = 0; i < 3; i++) begin
      total++; if ({q0, qb0} !== 8'b0011_1100) $display("FAIL pri_clr_wins[%0d]: got %b want 00111100", i, {q0, qb0}); else passed++;
      total++; if ({q1, qb1} !== 8'b1011_0100) $display("FAIL pri_set_wins[%0d]: got %b want 10110100", i, {q1, qb1}); else passed++;
      tick(1);
    end
    set_i[3] = 1'b0; clr_i[3] = 1'b0;
    tick(LAT + 2);
    total++; if (q0 !== 4'b0011) $display("FAIL pri_release0: got %b want 0011", q0); else passed++;
    total++; if (q1 !== 4'b1011) $display("FAIL pri_release1: got %b want 1011", q1); else passed++;
  endtask

  task automatic test_fall_with_set();
    set_i[2] = 1'b1;
    tick(LAT + 2);
    total++; if (q0 !== 4'b0111) $display("FAIL fws_preset: got %b want 0111", q0); else passed++;
    clr_fall_i[2] = 1'b0;
    tick(LAT);
    total++; if (q0 !== 4'b0011) $display("FAIL fws_dip: got %b want 0011", q0); else passed++;
    total++; if (q1 !== 4'b1111) $display("FAIL fws_set_dom: got %b want 1111", q1); else passed++;
    tick(1);
    total++; if (q0 !== 4'b0111) $display("FAIL fws_restore: got %b want 0111", q0); else passed++;
    total++; if (chg0 !== 4'b0100) $display("FAIL fws_chg_a: got %b want 0100", chg0); else passed++;
    tick(1);
    total++; if (chg0 !== 4'b0100) $display("FAIL fws_chg_b: got %b want 0100", chg0); else passed++;
    tick(1);
    total++; if (chg0 !== 4'b0000) $display("FAIL fws_chg_end: got %b want 0000", chg0); else passed++;
    total++; if (chg1 !== 4'b0000) $display("FAIL fws_chg1: got %b want 0000", chg1); else passed++;
    set_i[2] = 1'b0;
    tick(LAT + 2);
  endtask

`ifdef MIOC_FLOP_FILTER_EN
  task automatic test_filter();
    set_i[3] = 1'b1;
    tick(2);
    set_i[3] = 1'b0;
    tick(8);
    total++; if (q0 !== 4'b0111) $display("FAIL filt_glitch: got %b want 0111", q0); else passed++;
    set_i[3] = 1'b1;
    tick(3);
    set_i[3] = 1'b0;
    tick(2);
    total++; if (q0 !== 4'b0111) $display("FAIL filt_early: got %b want 0111", q0); else passed++;
    tick(1);
    total++; if (q0 !== 4'b1111) $display("FAIL filt_pass: got %b want 1111", q0); else passed++;
  endtask
`endif

  task automatic test_reset_mid();
    logic [CH-1:0] exp_q0;
`ifdef MIOC_FLOP_FILTER_EN
    exp_q0 = 4'b1111;
`else
    exp_q0 = 4'b0111;
`endif
    clr_fall_i = '1;
    tick(LAT + 3);
    total++; if (q0 !== exp_q0) $display("FAIL rise_no_clear: got %b want %b", q0, exp_q0); else passed++;
    set_i[3] = 1'b1;
    tick(LAT - 1);
    rst_n = 1'b0;
    set_i = '0;
    #1;
    total++; if (q0 !== 4'b0000) $display("FAIL async_rst_q0: got %b want 0000", q0); else passed++;
    total++; if (q1 !== 4'b0000) $display("FAIL async_rst_q1: got %b want 0000", q1); else passed++;
    total++; if ({qb0, chg0} !== 8'hF0) $display("FAIL async_rst_qbar_chg: got %h want f0", {qb0, chg0}); else passed++;
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      total++;
      if ({q0, chg0, q1, chg1} !== 16'h0000)
        $display("FAIL post_rst_idle[%0d]: got %h want 0000", i, {q0, chg0, q1, chg1});
      else passed++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_set_pulse();
    test_fall_clear();
    test_priority();
    test_fall_with_set();
`ifdef MIOC_FLOP_FILTER_EN
    test_filter();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
